// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch PC unit
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - architectural PC register with word-aligned load and +4 increment
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_en         load {load_target, 2'b00}; wins over inc_en
//   load_target     word address bits [XLEN-1:2] of the new PC
//   inc_en          advance PC by one word (wraps modulo 2^XLEN)
//   pc              current PC, bits [1:0] always 0
module pc_reg
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [XLEN-1:2]   load_target,
  input  logic              inc_en,
  output logic [XLEN-1:0]   pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = {load_target, 2'b00};
    end else if (inc_en) begin
      pc_d = pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register and single-outstanding instruction fetch sequencer
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   redirect_valid, redirect_target   taken branch/jump and its target
//   imem_req_valid/addr/ready         fetch request handshake (word aligned)
//   imem_rsp_valid/data               one-cycle response word
//   if_valid/pc/instr, if_ready       instruction handshake toward decode
//   misalign_err                      one-cycle pulse after a misaligned redirect
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [31:0]       if_instr,
  input  logic              if_ready,
  output logic              misalign_err
);

  fetch_state_e    state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            misalign_q, misalign_d;
  logic            pc_inc;
  logic [XLEN-1:0] pc;

  // A redirect always reloads the PC, whatever the state.
  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_en     (redirect_valid),
    .load_target (redirect_target[XLEN-1:2]),
    .inc_en      (pc_inc),
    .pc          (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      discard_q  <= 1'b0;
      req_pc_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pc_inc     = 1'b0;
    misalign_d = redirect_valid && (redirect_target[1:0] != 2'b00);
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_req_ready) begin
          state_d  = ST_WAIT;
          req_pc_d = pc;
          // A redirect racing the accept kills that fetch and suppresses the +4.
          if (redirect_valid) begin
            discard_d = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            state_d   = ST_FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == ST_FETCH);
    imem_req_addr  = pc;
    if_valid       = if_valid_q;
    if_pc          = if_pc_q;
    if_instr       = if_instr_q;
    misalign_err   = misalign_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .XLEN      (32),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .misalign_err    (misalign_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    if_ready        = 1'b0;
  endtask

  // Leaves the DUT in BOOT with inputs idle, at a falling edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] tgt;
    logic        rq_rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        ifr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [31:0] tgt, input logic rq_rdy,
                              input logic rsp_v, input logic [31:0] rsp_d, input logic ifr,
                              input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_mis);
    vec_t v;
    v.rd = rd; v.tgt = tgt; v.rq_rdy = rq_rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.ifr = ifr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  localparam int NVEC = 17;
  vec_t vt[NVEC];

  // Random-phase reference state: what the DUT should be showing at the next check.
  logic        m_outst, m_sq, m_hold, m_boot, m_mis, m_req, m_fire;
  logic [31:0] m_next, m_oaddr, m_hpc, m_hinstr;
  int          m_cd;

  task automatic model_reset();
    m_outst = 1'b0; m_sq = 1'b0; m_hold = 1'b0; m_boot = 1'b1; m_mis = 1'b0;
    m_next  = RST_PC; m_oaddr = '0; m_hpc = '0; m_hinstr = '0; m_cd = 0;
  endtask

  initial begin
    // Row: inputs applied after the check; expectations describe outputs at that check.
    vt[0]  = mk(0, 0,      0, 0, 0,            1, 0, 0,      0, 0, NOP,          0);
    vt[1]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h0,  0, 0, NOP,          0);
    vt[2]  = mk(0, 0,      0, 1, 32'h1111_0000, 1, 0, 0,     0, 0, NOP,          0);
    vt[3]  = mk(0, 0,      1, 0, 0,            1, 0, 0,      1, 32'h0, 32'h1111_0000, 0);
    vt[4]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h4,  0, 0, NOP,          0);
    vt[5]  = mk(0, 0,      0, 1, 32'h2222_0004, 1, 0, 0,     0, 0, NOP,          0);
    vt[6]  = mk(0, 0,      0, 0, 0,            1, 0, 0,      1, 32'h4, 32'h2222_0004, 0);
    vt[7]  = mk(0, 0,      1, 0, 0,            1, 1, 32'h8,  0, 0, NOP,          0);
    vt[8]  = mk(0, 0,      0, 1, 32'h3333_0008, 1, 0, 0,     0, 0, NOP,          0);
    vt[9]  = mk(1, 32'h203, 0, 0, 0,           1, 0, 0,      1, 32'h8, 32'h3333_0008, 0);
    vt[10] = mk(0, 0,      0, 0, 0,            0, 1, 32'h200, 0, 0, NOP,         1);
    vt[11] = mk(0, 0,      1, 0, 0,            0, 1, 32'h200, 0, 0, NOP,         0);
    vt[12] = mk(1, 32'h100, 0, 0, 0,           0, 0, 0,      0, 0, NOP,          0);
    vt[13] = mk(0, 0,      0, 0, 0,            0, 0, 0,      0, 0, NOP,          0);
    vt[14] = mk(0, 0,      0, 1, 32'hDEAD_BEEF, 1, 0, 0,     0, 0, NOP,          0);
    vt[15] = mk(0, 0,      0, 0, 0,            1, 1, 32'h100, 0, 0, NOP,         0);
    vt[16] = mk(0, 0,      0, 0, 0,            1, 1, 32'h100, 0, 0, NOP,         0);

    // Reset state
    do_reset();
    chk1 ("rst_req_valid", imem_req_valid, 1'b0);
    chk1 ("rst_if_valid",  if_valid,       1'b0);
    chk32("rst_if_pc",     if_pc,          RST_PC);
    chk32("rst_if_instr",  if_instr,       NOP);
    chk1 ("rst_misalign",  misalign_err,   1'b0);

    // Table: sequential fetch, redirect in HOLD (misaligned), redirect in WAIT
    for (int i = 0; i < NVEC; i++) begin
      chk1("tbl_req_valid", imem_req_valid, vt[i].e_req);
      if (vt[i].e_req) chk32("tbl_req_addr", imem_req_addr, vt[i].e_addr);
      chk1("tbl_if_valid", if_valid, vt[i].e_ifv);
      if (vt[i].e_ifv) chk32("tbl_if_pc", if_pc, vt[i].e_pc);
      chk32("tbl_if_instr", if_instr, vt[i].e_instr);
      chk1("tbl_misalign", misalign_err, vt[i].e_mis);
      redirect_valid  = vt[i].rd;
      redirect_target = vt[i].tgt;
      imem_req_ready  = vt[i].rq_rdy;
      imem_rsp_valid  = vt[i].rsp_v;
      imem_rsp_data   = vt[i].rsp_d;
      if_ready        = vt[i].ifr;
      @(negedge clk);
    end

    // HOLD with if_ready low for 5 cycles
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_5555;
    @(negedge clk);
    imem_rsp_valid = 1'b0; if_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk1 ("hold_if_valid",  if_valid,       1'b1);
      chk32("hold_if_pc",     if_pc,          32'h0);
      chk32("hold_if_instr",  if_instr,       32'hAAAA_5555);
      chk1 ("hold_req_valid", imem_req_valid, 1'b0);
      if (k == 5) if_ready = 1'b1;
      @(negedge clk);
    end
    if_ready = 1'b0;
    chk1 ("hold_rel_req_valid", imem_req_valid, 1'b1);
    chk32("hold_rel_req_addr",  imem_req_addr,  32'h4);
    chk1 ("hold_rel_if_valid",  if_valid,       1'b0);

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk32("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    chk1 ("wrap_next_req_valid", imem_req_valid, 1'b1);
    chk32("wrap_next_req_addr",  imem_req_addr,  32'h0);

    // Reset in WAIT, then a late response
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk1("rw_in_wait", imem_req_valid, 1'b0);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    chk1 ("rw_post_if_valid", if_valid, 1'b0);
    chk1 ("rw_post_req_valid", imem_req_valid, 1'b0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    chk1 ("rw_late_if_valid",  if_valid,       1'b0);
    chk1 ("rw_late_req_valid", imem_req_valid, 1'b1);
    chk32("rw_late_req_addr",  imem_req_addr,  RST_PC);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk1 ("rw_late2_if_valid", if_valid,       1'b0);
    chk32("rw_late2_if_instr", if_instr,       NOP);

    // Randomized run against the transaction-level reference
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_req = !(m_outst || m_hold || m_boot);
      chk1("rnd_req_valid", imem_req_valid, m_req);
      if (m_req) chk32("rnd_req_addr", imem_req_addr, m_next);
      chk1("rnd_if_valid", if_valid, m_hold);
      if (m_hold) begin
        chk32("rnd_if_pc",    if_pc,    m_hpc);
        chk32("rnd_if_instr", if_instr, m_hinstr);
      end else begin
        chk32("rnd_if_instr_nop", if_instr, NOP);
      end
      chk1("rnd_misalign", misalign_err, m_mis);

      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        chk1 ("rnd_rst_if_valid",  if_valid,       1'b0);
        chk32("rnd_rst_if_pc",     if_pc,          RST_PC);
        chk1 ("rnd_rst_req_valid", imem_req_valid, 1'b0);
        chk1 ("rnd_rst_misalign",  misalign_err,   1'b0);
        m_req = 1'b0;
      end

      redirect_valid  = ($urandom_range(0, 11) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? {30'h3FFF_FFFF, 2'($urandom)} : $urandom;
      imem_req_ready  = 1'($urandom_range(0, 1));
      if_ready        = ($urandom_range(0, 9) < 6);
      imem_rsp_data   = $urandom;
      if (m_outst) begin
        if (m_cd == 0) imem_rsp_valid = 1'b1;
        else begin
          imem_rsp_valid = 1'b0;
          m_cd--;
        end
      end else begin
        imem_rsp_valid = ($urandom_range(0, 7) == 0);
      end

      m_fire = m_req && imem_req_ready;
      m_mis  = redirect_valid && (redirect_target[1:0] != 2'b00);
      if (m_hold && (redirect_valid || if_ready)) m_hold = 1'b0;
      if (m_outst && imem_rsp_valid) begin
        if (!m_sq && !redirect_valid) begin
          m_hold   = 1'b1;
          m_hpc    = m_oaddr;
          m_hinstr = imem_rsp_data;
        end
        m_outst = 1'b0;
      end else if (m_outst && redirect_valid) begin
        m_sq = 1'b1;
      end
      if (m_fire) begin
        m_outst = 1'b1;
        m_oaddr = m_next;
        m_sq    = redirect_valid;
        m_cd    = $urandom_range(0, 3);
        m_next  = m_next + 32'd4;
      end
      if (redirect_valid) m_next = {redirect_target[31:2], 2'b00};
      m_boot = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
